// File: rtl/dest_hazard_unit_pkg.sv
// Shared constants for the hazard unit and the datapath operand muxes:
// register-number width and the operand-forwarding select encodings.
package dest_hazard_unit_pkg;

   localparam int unsigned REG_AW = 5;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_EX  = 2'd1,
      FWD_MEM = 2'd2,
      FWD_WB  = 2'd3
   } fwd_sel_e;

   // Youngest producer wins: EX over MEM over WB.
   function automatic fwd_sel_e fwd_pick(input logic ex_hit, input logic mem_hit,
                                         input logic wb_hit);
      fwd_sel_e sel;
      sel = FWD_RF;
      if (ex_hit) begin
         sel = FWD_EX;
      end else if (mem_hit) begin
         sel = FWD_MEM;
      end else if (wb_hit) begin
         sel = FWD_WB;
      end
      return sel;
   endfunction

endpackage

// File: rtl/dest_hazard_unit_slot.sv
// One pipeline slot {valid, we, is_load, dest} with async active-low clear.
// A bubble request loads an all-zero (invalid) slot instead of the input.
module dest_slot_reg #(
   parameter int unsigned REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bubble_i,
   input  logic              valid_i,
   input  logic              we_i,
   input  logic              is_load_i,
   input  logic [REG_AW-1:0] dest_i,
   output logic              valid_o,
   output logic              we_o,
   output logic              is_load_o,
   output logic [REG_AW-1:0] dest_o
);

   logic              valid_d, valid_q;
   logic              we_d, we_q;
   logic              is_load_d, is_load_q;
   logic [REG_AW-1:0] dest_d, dest_q;

   always_comb begin
      valid_d   = valid_i;
      we_d      = we_i;
      is_load_d = is_load_i;
      dest_d    = dest_i;
      if (bubble_i) begin
         valid_d   = 1'b0;
         we_d      = 1'b0;
         is_load_d = 1'b0;
         dest_d    = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         we_q      <= 1'b0;
         is_load_q <= 1'b0;
         dest_q    <= '0;
      end else begin
         valid_q   <= valid_d;
         we_q      <= we_d;
         is_load_q <= is_load_d;
         dest_q    <= dest_d;
      end
   end

   assign valid_o   = valid_q;
   assign we_o      = we_q;
   assign is_load_o = is_load_q;
   assign dest_o    = dest_q;

endmodule

// File: rtl/dest_hazard_unit.sv
// Destination-tracking hazard unit: EX/MEM/WB slot shadow, operand forwarding
// selects, load-use stall and a saturating stall-cycle counter.
module dest_hazard_unit #(
   parameter int unsigned REG_AW = dest_hazard_unit_pkg::REG_AW,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_rs_used,
   input  logic              id_rt_used,
   input  logic [REG_AW-1:0] id_dest,
   input  logic              id_we,
   input  logic              id_is_load,
   input  logic              flush,
   output logic              stall,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [REG_AW-1:0] wb_dest,
   output logic              wb_we,
   output logic [CNT_W-1:0]  stall_cnt
);

   import dest_hazard_unit_pkg::*;

   logic              ex_valid, ex_we, ex_ld;
   logic              mem_valid, mem_we, mem_ld;
   logic              wb_valid, wb_we_s, wb_ld;
   logic [REG_AW-1:0] ex_dest, mem_dest, wb_dest_s;
   logic              ex_bubble;

   assign ex_bubble = !(id_valid && !stall && !flush);

   dest_slot_reg #(.REG_AW(REG_AW)) u_ex_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .bubble_i  (ex_bubble),
      .valid_i   (id_valid),
      .we_i      (id_we),
      .is_load_i (id_is_load),
      .dest_i    (id_dest),
      .valid_o   (ex_valid),
      .we_o      (ex_we),
      .is_load_o (ex_ld),
      .dest_o    (ex_dest)
   );

   dest_slot_reg #(.REG_AW(REG_AW)) u_mem_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .bubble_i  (1'b0),
      .valid_i   (ex_valid),
      .we_i      (ex_we),
      .is_load_i (ex_ld),
      .dest_i    (ex_dest),
      .valid_o   (mem_valid),
      .we_o      (mem_we),
      .is_load_o (mem_ld),
      .dest_o    (mem_dest)
   );

   dest_slot_reg #(.REG_AW(REG_AW)) u_wb_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .bubble_i  (1'b0),
      .valid_i   (mem_valid),
      .we_i      (mem_we),
      .is_load_i (mem_ld),
      .dest_i    (mem_dest),
      .valid_o   (wb_valid),
      .we_o      (wb_we_s),
      .is_load_o (wb_ld),
      .dest_o    (wb_dest_s)
   );

   // "Writing r": valid producer of a non-zero destination equal to r.
   logic ex_wr_rs, mem_wr_rs, wb_wr_rs;
   logic ex_wr_rt, mem_wr_rt, wb_wr_rt;
   logic rs_nz, rt_nz;

   always_comb begin
      rs_nz     = (id_rs != '0);
      rt_nz     = (id_rt != '0);
      ex_wr_rs  = ex_valid  && ex_we   && (ex_dest   == id_rs) && rs_nz;
      mem_wr_rs = mem_valid && mem_we  && (mem_dest  == id_rs) && rs_nz;
      wb_wr_rs  = wb_valid  && wb_we_s && (wb_dest_s == id_rs) && rs_nz;
      ex_wr_rt  = ex_valid  && ex_we   && (ex_dest   == id_rt) && rt_nz;
      mem_wr_rt = mem_valid && mem_we  && (mem_dest  == id_rt) && rt_nz;
      wb_wr_rt  = wb_valid  && wb_we_s && (wb_dest_s == id_rt) && rt_nz;
   end

   always_comb begin
      stall = id_valid && ex_ld &&
              ((id_rs_used && ex_wr_rs) || (id_rt_used && ex_wr_rt));
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
      if (!stall && id_rs_used) begin
         fwd_a = fwd_pick(ex_wr_rs, mem_wr_rs, wb_wr_rs);
      end
      if (!stall && id_rt_used) begin
         fwd_b = fwd_pick(ex_wr_rt, mem_wr_rt, wb_wr_rt);
      end
   end

   // A flushed stall never reaches EX, so it is not a lost cycle.
   logic [CNT_W-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (stall && !flush && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign stall_cnt = cnt_q;
   assign wb_dest   = wb_dest_s;
   assign wb_we     = wb_valid && wb_we_s && (wb_dest_s != '0);

   logic unused_ld;
   assign unused_ld = wb_ld;

endmodule

// File: tb/tb_dest_hazard_unit.sv
// Self-checking bench: directed cycle table, reset sequences and a random
// phase compared against a queue-style pipeline model.
module tb_dest_hazard_unit;

   localparam int AW      = 5;
   localparam int CW      = 4;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          clk, rst_n;
   logic          id_valid, id_rs_used, id_rt_used, id_we, id_is_load, flush;
   logic [AW-1:0] id_rs, id_rt, id_dest;
   logic          stall, wb_we;
   logic [1:0]    fwd_a, fwd_b;
   logic [AW-1:0] wb_dest;
   logic [CW-1:0] stall_cnt;

   dest_hazard_unit #(.REG_AW(AW), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .id_valid   (id_valid),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_rs_used (id_rs_used),
      .id_rt_used (id_rt_used),
      .id_dest    (id_dest),
      .id_we      (id_we),
      .id_is_load (id_is_load),
      .flush      (flush),
      .stall      (stall),
      .fwd_a      (fwd_a),
      .fwd_b      (fwd_b),
      .wb_dest    (wb_dest),
      .wb_we      (wb_we),
      .stall_cnt  (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic drive(input logic v, input int rs, input int rt, input logic ru,
                        input logic tu, input int dst, input logic we, input logic ld,
                        input logic fl);
      id_valid   = v;
      id_rs      = AW'(rs);
      id_rt      = AW'(rt);
      id_rs_used = ru;
      id_rt_used = tu;
      id_dest    = AW'(dst);
      id_we      = we;
      id_is_load = ld;
      flush      = fl;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " stall"}, 32'(stall), 0);
      chk({tag, " fwd_a"}, 32'(fwd_a), 0);
      chk({tag, " fwd_b"}, 32'(fwd_b), 0);
      chk({tag, " wb_we"}, 32'(wb_we), 0);
      chk({tag, " wb_dest"}, 32'(wb_dest), 0);
      chk({tag, " stall_cnt"}, 32'(stall_cnt), 0);
   endtask

   // Directed per-cycle vectors; expectations are the outputs before the edge.
   typedef struct {
      logic v; int rs; int rt; logic ru; logic tu; int dst; logic we; logic ld; logic fl;
      logic st; int fa; int fb; logic wbwe; int cnt;
   } vec_t;

   function automatic vec_t mk(input logic v, input int rs, input int rt, input logic ru,
                               input logic tu, input int dst, input logic we,
                               input logic ld, input logic fl, input logic st,
                               input int fa, input int fb, input logic wbwe, input int cnt);
      vec_t r;
      r.v = v; r.rs = rs; r.rt = rt; r.ru = ru; r.tu = tu; r.dst = dst; r.we = we;
      r.ld = ld; r.fl = fl; r.st = st; r.fa = fa; r.fb = fb; r.wbwe = wbwe; r.cnt = cnt;
      return r;
   endfunction

   // Reference model: three ages of in-flight instructions, index 0 = youngest.
   int m_v[3], m_we[3], m_ld[3], m_dst[3];
   int m_cnt;

   function automatic bit m_writing(input int k, input int r);
      return m_v[k] != 0 && m_we[k] != 0 && m_dst[k] == r && r != 0;
   endfunction

   function automatic bit m_stall();
      return id_valid && m_ld[0] != 0 &&
             ((id_rs_used && m_writing(0, int'(id_rs))) ||
              (id_rt_used && m_writing(0, int'(id_rt))));
   endfunction

   function automatic int m_fwd(input int r, input bit used);
      if (!used || m_stall()) return 0;
      for (int k = 0; k < 3; k++) if (m_writing(k, r)) return k + 1;
      return 0;
   endfunction

   task automatic m_reset();
      for (int k = 0; k < 3; k++) begin
         m_v[k] = 0; m_we[k] = 0; m_ld[k] = 0; m_dst[k] = 0;
      end
      m_cnt = 0;
   endtask

   task automatic m_step();
      bit st;
      st = m_stall();
      for (int k = 2; k > 0; k--) begin
         m_v[k] = m_v[k-1]; m_we[k] = m_we[k-1]; m_ld[k] = m_ld[k-1]; m_dst[k] = m_dst[k-1];
      end
      if (id_valid && !st && !flush) begin
         m_v[0] = 1; m_we[0] = int'(id_we); m_ld[0] = int'(id_is_load);
         m_dst[0] = int'(id_dest);
      end else begin
         m_v[0] = 0; m_we[0] = 0; m_ld[0] = 0; m_dst[0] = 0;
      end
      if (st && !flush && m_cnt < CNT_MAX) m_cnt++;
   endtask

   vec_t tbl[18];

   initial begin
      tbl[0]  = mk(1, 1, 2, 1, 1,  3, 1, 0, 0,  0, 0, 0, 0, 0); // add r3
      tbl[1]  = mk(1, 3, 4, 1, 1,  6, 1, 0, 0,  0, 1, 0, 0, 0); // sub rs=r3
      tbl[2]  = mk(1, 1, 0, 1, 0,  5, 1, 1, 0,  0, 0, 0, 0, 0); // lw r5
      tbl[3]  = mk(1, 5, 6, 1, 1,  7, 1, 0, 0,  1, 0, 0, 1, 0); // load-use stall
      tbl[4]  = mk(1, 5, 6, 1, 1,  7, 1, 0, 0,  0, 2, 3, 1, 1); // replay
      tbl[5]  = mk(1, 0, 0, 0, 0,  7, 1, 0, 0,  0, 0, 0, 1, 1);
      tbl[6]  = mk(1, 0, 0, 0, 0,  7, 1, 0, 0,  0, 0, 0, 0, 1);
      tbl[7]  = mk(1, 0, 7, 0, 1,  0, 0, 0, 0,  0, 0, 1, 1, 1); // r7 in EX/MEM/WB
      tbl[8]  = mk(1, 0, 7, 0, 1,  0, 0, 0, 0,  0, 0, 2, 1, 1); // r7 in MEM/WB
      tbl[9]  = mk(1, 0, 0, 0, 0,  0, 1, 1, 0,  0, 0, 0, 1, 1); // lw r0
      tbl[10] = mk(1, 0, 0, 1, 1,  9, 1, 0, 0,  0, 0, 0, 0, 1); // add rs=r0
      tbl[11] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 1);
      tbl[12] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 1); // lw r0 in WB
      tbl[13] = mk(1, 0, 0, 0, 0, 10, 1, 1, 0,  0, 0, 0, 1, 1); // lw r10
      tbl[14] = mk(1, 10, 0, 1, 0, 11, 1, 0, 1, 1, 0, 0, 0, 1); // load-use + flush
      tbl[15] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 1);
      tbl[16] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 1, 1); // lw r10 in WB
      tbl[17] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 1); // flushed slot in WB

      // Reset state, with ID inputs that would otherwise forward.
      rst_n = 1'b0;
      drive(1, 3, 3, 1, 1, 3, 1, 1, 0);
      #2;
      chk_all_zero("in_reset");
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         drive(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].ru, tbl[i].tu, tbl[i].dst,
               tbl[i].we, tbl[i].ld, tbl[i].fl);
         #1;
         chk($sformatf("vec%0d stall", i), 32'(stall), 32'(tbl[i].st));
         chk($sformatf("vec%0d fwd_a", i), 32'(fwd_a), tbl[i].fa);
         chk($sformatf("vec%0d fwd_b", i), 32'(fwd_b), tbl[i].fb);
         chk($sformatf("vec%0d wb_we", i), 32'(wb_we), 32'(tbl[i].wbwe));
         chk($sformatf("vec%0d stall_cnt", i), 32'(stall_cnt), tbl[i].cnt);
         @(negedge clk);
      end

      // Async reset mid-stall: load in EX must vanish and never write back.
      drive(1, 0, 0, 0, 0, 5, 1, 1, 0);
      @(negedge clk);
      drive(1, 5, 0, 1, 0, 8, 1, 0, 0);
      #1;
      chk("pre_reset stall", 32'(stall), 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk_all_zero("async_reset");
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk($sformatf("post_reset%0d wb_we", i), 32'(wb_we), 0);
         chk($sformatf("post_reset%0d stall_cnt", i), 32'(stall_cnt), 0);
      end

      // Random phase against the model, starting from a fresh reset.
      @(negedge clk);
      rst_n = 1'b0;
      m_reset();
      #2;
      rst_n = 1'b1;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         drive($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, $urandom_range(0, 3),
               $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 4,
               $urandom_range(0, 9) == 0);
         #1;
         chk($sformatf("rnd%0d stall", c), 32'(stall), 32'(m_stall()));
         chk($sformatf("rnd%0d fwd_a", c), 32'(fwd_a), m_fwd(int'(id_rs), id_rs_used));
         chk($sformatf("rnd%0d fwd_b", c), 32'(fwd_b), m_fwd(int'(id_rt), id_rt_used));
         chk($sformatf("rnd%0d wb_we", c), 32'(wb_we),
             32'(m_v[2] != 0 && m_we[2] != 0 && m_dst[2] != 0));
         chk($sformatf("rnd%0d wb_dest", c), 32'(wb_dest), m_dst[2]);
         chk($sformatf("rnd%0d stall_cnt", c), 32'(stall_cnt), m_cnt);
         @(posedge clk);
         m_step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/dest_hazard_unit.md
DEST_HAZARD_UNIT -- requirements
Module: dest_hazard_unit

Interface
REQ-001 The module SHALL have parameter REG_AW, default 5, which is the register-number width (32 architectural registers).
REQ-002 The module SHALL have parameter CNT_W, default 16, which is the width of the stall performance counter.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The module SHALL have port id_valid, input, 1 bit: the ID stage holds a real instruction.
REQ-006 The module SHALL have ports id_rs and id_rt, input, REG_AW bits each: the ID source register numbers.
REQ-007 The module SHALL have ports id_rs_used and id_rt_used, input, 1 bit each: the instruction reads that source.
REQ-008 The module SHALL have port id_dest, input, REG_AW bits: the destination register, already selected between rt and rd upstream.
REQ-009 The module SHALL have port id_we, input, 1 bit: the instruction writes id_dest.
REQ-010 The module SHALL have port id_is_load, input, 1 bit: the instruction is a memory load.
REQ-011 The module SHALL have port flush, input, 1 bit: squash the instruction entering EX (branch taken).
REQ-012 The module SHALL have port stall, output, 1 bit: hold PC and IF/ID, and insert a bubble into EX.
REQ-013 The module SHALL have ports fwd_a and fwd_b, output, 2 bits each: the operand source for rs/rt; 0=regfile, 1=EX result, 2=MEM result, 3=WB result.
REQ-014 The module SHALL have ports wb_dest (output, REG_AW bits) and wb_we (output, 1 bit): the register-file write address and write enable.
REQ-015 The module SHALL have port stall_cnt, output, CNT_W bits: the number of stall cycles, saturating.

Function
REQ-016 The module SHALL track three slots (EX, MEM, WB); each slot SHALL hold {valid, we, is_load, dest}.
REQ-017 On each clock edge, WB SHALL take MEM and MEM SHALL take EX.
REQ-018 On each clock edge, EX SHALL take the ID fields when id_valid=1, stall=0 and flush=0; otherwise EX SHALL become a bubble (valid=0).
REQ-019 A slot SHALL be "writing r" only when valid=1, we=1, dest=r and r!=0.
REQ-020 Register 0 SHALL never forward and never cause a stall.
REQ-021 fwd_a SHALL equal 1 if id_rs_used=1 and EX is writing id_rs, else 2 if MEM is writing id_rs, else 3 if WB is writing id_rs, else 0; the priority SHALL be EX > MEM > WB.
REQ-022 fwd_b SHALL follow the same rule as fwd_a using id_rt and id_rt_used.
REQ-023 fwd_a, fwd_b and stall SHALL be combinational from the current slot state and the ID inputs, with zero latency.
REQ-024 stall SHALL be 1 when id_valid=1, EX.is_load=1 and EX is writing a used source (load-use).
REQ-025 A load-use stall SHALL last exactly 1 cycle; the next cycle the load is in MEM and the operand is forwarded with code 2.
REQ-026 When stall=1, fwd_a and fwd_b SHALL be forced to 0.
REQ-027 When flush=1 and stall=1 occur in the same cycle, flush SHALL win: EX becomes a bubble and the stall is not counted.
REQ-028 wb_dest SHALL equal WB.dest; wb_we SHALL equal WB.valid & WB.we & (WB.dest!=0).
REQ-029 stall_cnt SHALL increment on each edge where stall=1 and flush=0, and SHALL hold at all-ones.

Reset
REQ-030 While rst_n=0, the module SHALL asynchronously clear all slots to valid=0, we=0, is_load=0, dest=0, and clear stall_cnt to 0.
REQ-031 During and after reset, the outputs SHALL be stall=0, fwd_a=fwd_b=0, wb_we=0, wb_dest=0 and stall_cnt=0.
REQ-032 When reset is asserted mid-stall, the module SHALL discard the in-flight load; no write-back occurs.

Structure
REQ-033 The fwd_* encodings (FWD_RF/EX/MEM/WB) and REG_AW SHALL be defined in a shared constants package/include used by the datapath operand muxes.
REQ-034 The module SHALL contain one sub-module, dest_slot_reg, a single slot register with async active-low clear and a bubble input, instantiated three times.

Verification
REQ-035 The bench SHALL check the ALU-ALU back-to-back case: add r3 then sub using rs=r3 -> fwd_a=1 in the sub's ID cycle, and stall=0.
REQ-036 The bench SHALL check load-use: lw r5 then add rs=r5 -> stall=1 for one cycle, then fwd_a=2 with stall=0, and stall_cnt=1.
REQ-037 The bench SHALL check priority: EX, MEM and WB all writing r7, ID rt=r7 -> fwd_b=1; with only MEM and WB writing r7 -> fwd_b=2.
REQ-038 The bench SHALL check register 0: lw r0 then add rs=r0 -> stall=0, fwd_a=0, and wb_we=0 when it reaches WB.
REQ-039 The bench SHALL check flush precedence: load-use hazard with flush=1 in the same cycle -> EX bubble, stall_cnt unchanged, and three cycles later wb_we=0.
REQ-040 The bench SHALL check async reset: rst_n pulsed low between clock edges mid-pipeline -> all outputs 0 immediately, and stall_cnt=0.
